// File: rtl/wash_cycle_sequencer_if.sv
// Washer sequencer bus: control pulses and sensors in, actuators and status out.
interface wash_cycle_sequencer_if;
  logic       start;
  logic       abort;
  logic       tick;
  logic       door_closed;
  logic       water_full;
  logic       water_empty;
  logic       valve_enable;
  logic       drain_enable;
  logic       motor_on;
  logic       motor_fast;
  logic       door_lock;
  logic [3:0] stage;
  logic       done;
  logic       fault;

  // Sequencer side
  modport slave (
    input  start, abort, tick, door_closed, water_full, water_empty,
    output valve_enable, drain_enable, motor_on, motor_fast, door_lock,
           stage, done, fault
  );

  // Controller / environment side
  modport master (
    output start, abort, tick, door_closed, water_full, water_empty,
    input  valve_enable, drain_enable, motor_on, motor_fast, door_lock,
           stage, done, fault
  );
endinterface

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine cycle sequencer: fill, wash, drain, N rinses, spin.
// Registered Moore FSM with stage timer, rinse counter, door-open pause and abort drain.
// Optional feature macro WASH_FILL_TIMEOUT_EN: fill/drain watchdog that ends in FAULT.
module wash_cycle_sequencer #(
  parameter int unsigned TIMER_W     = 16,
  parameter int unsigned WASH_TICKS  = 600,
  parameter int unsigned RINSE_TICKS = 300,
  parameter int unsigned SPIN_TICKS  = 240,
  parameter int unsigned RINSE_COUNT = 2,
  parameter int unsigned FILL_LIMIT  = 180
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wash_cycle_sequencer_if.slave bus
);

  localparam int unsigned RINSE_W = 3;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_WASH   = 4'd2,
    S_DRAIN  = 4'd3,
    S_RFILL  = 4'd4,
    S_RINSE  = 4'd5,
    S_RDRAIN = 4'd6,
    S_SPIN   = 4'd7,
    S_DONE   = 4'd8,
    S_PAUSE  = 4'd9,
    S_FAULT  = 4'd10,
    S_ADRAIN = 4'd11
  } state_e;

  state_e               state_q, state_d;
  state_e               saved_q, saved_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [RINSE_W-1:0]   rinse_q, rinse_d;
  logic                 pause_ok;
  logic                 abort_ok;

  logic                 valve_q, valve_d;
  logic                 drain_q, drain_d;
  logic                 motor_q, motor_d;
  logic                 fast_q, fast_d;
  logic                 lock_q, lock_d;
  logic [3:0]           stage_q, stage_d;
  logic                 done_q, done_d;
  logic                 fault_q, fault_d;

`ifdef WASH_FILL_TIMEOUT_EN
  localparam int unsigned WAIT_W = (FILL_LIMIT > 1) ? $clog2(FILL_LIMIT) : 1;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 sensor_wait;
`else
  logic                 fill_limit_unused;
  assign fill_limit_unused = (FILL_LIMIT != 0);
`endif

  // Next-state, timer, rinse counter and saved-state logic
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    timer_d  = timer_q;
    rinse_d  = rinse_q;
    pause_ok = state_q inside {S_FILL, S_WASH, S_RFILL, S_RINSE, S_SPIN};
    abort_ok = !(state_q inside {S_IDLE, S_DONE, S_FAULT, S_ADRAIN});

    if (abort_ok && bus.abort) begin
      state_d = S_ADRAIN;
    end else if (pause_ok && !bus.door_closed) begin
      // Timer and rinse count hold; a coincident tick is dropped
      state_d = S_PAUSE;
      saved_d = state_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && bus.door_closed) state_d = S_FILL;
        end
        S_FILL: begin
          if (bus.water_full) begin
            state_d = S_WASH;
            timer_d = TIMER_W'(WASH_TICKS);
          end
        end
        S_WASH: begin
          if (bus.tick) begin
            timer_d = timer_q - TIMER_W'(1);
            if (timer_q == TIMER_W'(1)) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.water_empty) begin
            state_d = S_RFILL;
            rinse_d = '0;
          end
        end
        S_RFILL: begin
          if (bus.water_full) begin
            state_d = S_RINSE;
            timer_d = TIMER_W'(RINSE_TICKS);
          end
        end
        S_RINSE: begin
          if (bus.tick) begin
            timer_d = timer_q - TIMER_W'(1);
            if (timer_q == TIMER_W'(1)) state_d = S_RDRAIN;
          end
        end
        S_RDRAIN: begin
          if (bus.water_empty) begin
            rinse_d = rinse_q + RINSE_W'(1);
            if (rinse_d == RINSE_W'(RINSE_COUNT)) begin
              state_d = S_SPIN;
              timer_d = TIMER_W'(SPIN_TICKS);
            end else begin
              state_d = S_RFILL;
            end
          end
        end
        S_SPIN: begin
          if (bus.tick) begin
            timer_d = timer_q - TIMER_W'(1);
            if (timer_q == TIMER_W'(1)) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.start) state_d = S_IDLE;
        end
        S_PAUSE: begin
          if (bus.start && bus.door_closed) state_d = saved_q;
        end
        S_ADRAIN: begin
          if (bus.water_empty) state_d = S_IDLE;
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

`ifdef WASH_FILL_TIMEOUT_EN
    // Watchdog on sensor-terminated states; frozen across a pause, cleared on any other entry
    wait_d      = wait_q;
    sensor_wait = state_q inside {S_FILL, S_RFILL, S_DRAIN, S_RDRAIN, S_ADRAIN};
    if (state_d == state_q) begin
      if (sensor_wait && bus.tick) begin
        if (wait_q == WAIT_W'(FILL_LIMIT - 1)) begin
          state_d = S_FAULT;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
    end else if ((state_d != S_PAUSE) && !((state_q == S_PAUSE) && (state_d == saved_q))) begin
      wait_d = '0;
    end
`endif
  end

  // Output decode from the next state so outputs land registered with the state
  always_comb begin
    valve_d = state_d inside {S_FILL, S_RFILL};
    drain_d = state_d inside {S_DRAIN, S_RDRAIN, S_SPIN, S_ADRAIN};
    motor_d = state_d inside {S_WASH, S_RINSE, S_SPIN};
    fast_d  = (state_d == S_SPIN);
    lock_d  = !(state_d inside {S_IDLE, S_DONE, S_PAUSE, S_FAULT});
    stage_d = state_d;
    done_d  = (state_d == S_DONE);
`ifdef WASH_FILL_TIMEOUT_EN
    fault_d = (state_d == S_FAULT);
`else
    fault_d = 1'b0;
`endif
  end

  // State, timer and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      saved_q <= S_IDLE;
      timer_q <= '0;
      rinse_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      timer_q <= timer_d;
      rinse_q <= rinse_d;
    end
  end

`ifdef WASH_FILL_TIMEOUT_EN
  // Watchdog tick counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`endif

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valve_q <= 1'b0;
      drain_q <= 1'b0;
      motor_q <= 1'b0;
      fast_q  <= 1'b0;
      lock_q  <= 1'b0;
      stage_q <= 4'd0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      valve_q <= valve_d;
      drain_q <= drain_d;
      motor_q <= motor_d;
      fast_q  <= fast_d;
      lock_q  <= lock_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign bus.valve_enable = valve_q;
  assign bus.drain_enable = drain_q;
  assign bus.motor_on     = motor_q;
  assign bus.motor_fast   = fast_q;
  assign bus.door_lock    = lock_q;
  assign bus.stage        = stage_q;
  assign bus.done         = done_q;
  assign bus.fault        = fault_q;

endmodule

// File: doc/wash_cycle_sequencer.md
# wash_cycle_sequencer

Parametrised washing-machine cycle sequencer for the controller datapath. It takes a start request, door and water-level sensors and a prescaled time tick. It steps through fill, wash, drain, a configurable number of rinses and a spin, driving the valve, drain pump, motor and door lock. It replaces the fixed 13-entry stage decoder with a registered Moore FSM, a built-in stage timer, a rinse counter, door-open pause/resume and abort handling.

## Interface
- TIMER_W, 16: stage timer width in bits.
- WASH_TICKS, 600: wash agitation duration in ticks (1 to 2^TIMER_W-1).
- RINSE_TICKS, 300: duration of each rinse agitation in ticks.
- SPIN_TICKS, 240: spin duration in ticks.
- RINSE_COUNT, 2: number of rinse passes (1 to 7).
- FILL_LIMIT, 180: fill/drain timeout in ticks; used only with the macro.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  single-cycle pulse; starts a cycle from IDLE or resumes from PAUSE.
- abort  in  1  single-cycle pulse; cancels the cycle.
- tick  in  1  single-cycle time-base pulse (e.g. 1 Hz).
- door_closed  in  1  door switch, 1 = closed.
- water_full  in  1  level sensor, high level reached.
- water_empty  in  1  level sensor, drum empty.
- valve_enable  out  1  inlet water valve.
- drain_enable  out  1  drain pump.
- motor_on  out  1  drum motor.
- motor_fast  out  1  spin speed (valid only with motor_on).
- door_lock  out  1  door latch.
- stage  out  4  current state code.
- done  out  1  1 while in DONE.
- fault  out  1  1 while in FAULT.

## Operation
- State codes:
  - IDLE 0, FILL 1, WASH 2, DRAIN 3, RFILL 4, RINSE 5, RDRAIN 6, SPIN 7.
  - DONE 8, PAUSE 9, FAULT 10, ADRAIN 11.
- Outputs are decoded from registered state only (Moore).
- valve_enable: FILL, RFILL.
- drain_enable: DRAIN, RDRAIN, SPIN, ADRAIN.
- motor_on: WASH, RINSE, SPIN; motor_fast: SPIN only.
- door_lock: every state except IDLE, DONE, PAUSE, FAULT.
- Transitions:
  - IDLE→FILL on start with door_closed; start is ignored while the door is open.
  - FILL→WASH on water_full.
  - WASH→DRAIN on timer expiry.
  - DRAIN→RFILL on water_empty; rinse_cnt is cleared to 0.
  - RFILL→RINSE on water_full.
  - RINSE→RDRAIN on timer expiry.
  - RDRAIN on water_empty: increment rinse_cnt, then go to SPIN if the new value equals RINSE_COUNT, else RFILL.
  - SPIN→DONE on timer expiry.
  - DONE→IDLE on start; the same pulse does not also start a new cycle.
- Timer:
  - Loaded with the stage duration on entry to WASH, RINSE or SPIN.
  - Decrements on each tick while in that state.
  - Expiry is the tick that takes it from 1 to 0; the state changes on that clock edge.
  - A stage therefore lasts exactly N ticks.
- Pause:
  - door_closed=0 in FILL, WASH, RFILL, RINSE or SPIN → PAUSE.
  - The interrupted state is saved; the timer and rinse_cnt are frozen.
  - PAUSE returns to the saved state on start with door_closed, and the timer resumes from its frozen value.
  - door_closed is not monitored in drain states (tub empty, lock held).
- Abort:
  - abort in any state other than IDLE, DONE, FAULT or ADRAIN → ADRAIN.
  - ADRAIN→IDLE on water_empty.
  - abort in PAUSE also goes to ADRAIN and relocks the door.
- Simultaneous events, priority: abort > door-open pause > normal transition.
- A tick arriving in the same cycle as the pause is not counted.
- Reset: state IDLE, timer 0, rinse_cnt 0, saved state IDLE; all outputs 0 and stage=0. Reset mid-cycle abandons the cycle with no drain.

## Timing
- Output latency: one clk after the qualifying input edge is sampled.
- Inputs are sampled synchronously. The sensor inputs (door_closed, water_full, water_empty) are synchronised upstream.
- start, abort and tick are one-cycle pulses. Wider pulses act as repeated events.
- No combinational input-to-output paths.

## Configuration
- WASH_FILL_TIMEOUT_EN defined:
  - A tick counter runs in FILL, RFILL, DRAIN, RDRAIN and ADRAIN.
  - If the exit sensor is not seen within FILL_LIMIT ticks, go to FAULT (all actuators off, fault=1).
  - FAULT exits only on rst_n.
- Not defined: these states wait indefinitely, FAULT is unreachable and fault is tied 0.

## Test plan
- Nominal: WASH_TICKS=3, RINSE_TICKS=2, SPIN_TICKS=2, RINSE_COUNT=2; start, then sensors driven on each fill/drain → stage sequence 1,2,3,4,5,6,4,5,6,7,8; done=1; WASH lasts exactly 3 ticks.
- Pause: door opened after 1 tick of WASH, then closed and start pulsed → PAUSE with all outputs 0; on return, WASH ends after exactly 2 more ticks.
- Abort in RINSE → ADRAIN with drain_enable=1 and door_lock=1; water_empty → IDLE with all outputs 0.
- Priority: abort and door-open in the same cycle during SPIN → ADRAIN, not PAUSE.
- Timeout (macro on, FILL_LIMIT=4): start with water_full held 0 → FAULT after the 4th tick; fault=1 and valve_enable=0; start is ignored until rst_n.
- Reset mid-SPIN: rst_n low → stage=0 and all outputs 0 immediately (asynchronous); start after release → FILL.
